// File: rtl/gpr_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package gpr_mp_pkg;

  localparam int GPR_ZERO_ADDR = 0;
  localparam int DEF_DW        = 32;
  localparam int DEF_AW        = 5;
  localparam int DEF_NREG      = 32;

  function automatic int byte_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/gpr_rd_mux.sv
// One read port: stored-word lookup, per-byte write bypass (port 1 over port 0)
// and forcing of register 0 to zero.
module gpr_rd_mux
  import gpr_mp_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = DEF_AW,
  parameter int BYPASS = 1
) (
  input  logic [DW-1:0]            regs [NREG],
  input  logic [AW-1:0]            raddr,
  input  logic                     we0,
  input  logic [AW-1:0]            waddr0,
  input  logic [DW-1:0]            wdata0,
  input  logic [byte_lanes(DW)-1:0] wbe0,
  input  logic                     we1,
  input  logic [AW-1:0]            waddr1,
  input  logic [DW-1:0]            wdata1,
  input  logic [byte_lanes(DW)-1:0] wbe1,
  output logic [DW-1:0]            rdata
);

  localparam int NB = byte_lanes(DW);

  logic hit0, hit1;

  assign hit0 = we0 && (waddr0 == raddr);
  assign hit1 = we1 && (waddr1 == raddr);

  // NOTE: combinational outputs take a full default first so no path infers a latch.
  always_comb begin
    rdata = regs[raddr];
    if (BYPASS != 0) begin
      for (int b = 0; b < NB; b++) begin
        if (hit1 && wbe1[b]) begin
          rdata[8*b +: 8] = wdata1[8*b +: 8];
        end else if (hit0 && wbe0[b]) begin
          rdata[8*b +: 8] = wdata0[8*b +: 8];
        end
      end
    end
    // r0 override comes last so bypassed writes to address 0 never leak out.
    if (raddr == AW'(GPR_ZERO_ADDR)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port register file: two byte-masked write ports with port-1 priority,
// NRD combinational read ports with optional same-cycle write bypass.
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = DEF_AW,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SIG_RF_W0,
  input  logic [AW-1:0]             waddr0,
  input  logic [DW-1:0]             wdata0,
  input  logic [byte_lanes(DW)-1:0] wbe0,
  input  logic                      SIG_RF_W1,
  input  logic [AW-1:0]             waddr1,
  input  logic [DW-1:0]             wdata1,
  input  logic [byte_lanes(DW)-1:0] wbe1,
  input  logic [NRD*AW-1:0]         raddr,
  output logic [NRD*DW-1:0]         rdata
);

  localparam int NB = byte_lanes(DW);

  logic [DW-1:0] regs [NREG];
  logic          we0_act, we1_act;

  // Writes (and therefore bypass) are suppressed while reset is held.
  assign we0_act = SIG_RF_W0 && rst;
  assign we1_act = SIG_RF_W1 && rst;

  // NOTE: the array is deliberately reset so no register ever reads X; r0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int b = 0; b < NB; b++) begin
          if (SIG_RF_W1 && (waddr1 == AW'(r)) && wbe1[b]) begin
            regs[r][8*b +: 8] <= wdata1[8*b +: 8];
          end else if (SIG_RF_W0 && (waddr0 == AW'(r)) && wbe0[b]) begin
            regs[r][8*b +: 8] <= wdata0[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    gpr_rd_mux #(
      .DW     (DW),
      .NREG   (NREG),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd_mux (
      .regs   (regs),
      .raddr  (raddr[k*AW +: AW]),
      .we0    (we0_act),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .wbe0   (wbe0),
      .we1    (we1_act),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .wbe1   (wbe1),
      .rdata  (rdata[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Scoreboard bench for gpr_mp: a bypass and a non-bypass instance share stimulus.
module tb_gpr_mp;

  logic        clk;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wbe0, wbe1;
  logic [9:0]  raddr;
  logic [63:0] rdata_b1, rdata_b0;

  typedef struct {
    string       name;
    int          dut;   // 1 = bypass instance, 0 = non-bypass instance
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event do_check;
  int   n_tests = 0;
  int   n_fail  = 0;

  gpr_mp #(.BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .SIG_RF_W0(we0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
    .SIG_RF_W1(we1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
    .raddr(raddr), .rdata(rdata_b1)
  );

  gpr_mp #(.BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst),
    .SIG_RF_W0(we0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
    .SIG_RF_W1(we1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
    .raddr(raddr), .rdata(rdata_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drains the scoreboard each time a sample point is announced.
  initial begin
    forever begin
      @(do_check);
      while (sb_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e   = sb_q.pop_front();
        act = (e.dut == 1) ? rdata_b1[e.port*32 +: 32] : rdata_b0[e.port*32 +: 32];
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s bypass=%0d port=%0d got=%h exp=%h", e.name, e.dut, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0; wbe0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; wbe1 = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    if (p == 0) begin
      we0 = 1'b1; waddr0 = a; wdata0 = d; wbe0 = be;
    end else begin
      we1 = 1'b1; waddr1 = a; wdata1 = d; wbe1 = be;
    end
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic expect_rd(input string name, input int port, input logic [31:0] e_b1, input logic [31:0] e_b0);
    exp_t e;
    e.name = name; e.port = port;
    e.dut = 1; e.exp = e_b1; sb_q.push_back(e);
    e.dut = 0; e.exp = e_b0; sb_q.push_back(e);
  endtask

  task automatic sample(input int dly);
    #(dly);
    -> do_check;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rd(5'd0, 5'd0);

    // Write attempted during reset: no bypass, no update.
    @(negedge clk);
    wr(0, 5'd1, 32'h0000_0233, 4'hF);
    rd(5'd1, 5'd0);
    expect_rd("in_reset_rd0", 0, 32'h0, 32'h0);
    expect_rd("in_reset_rd1", 1, 32'h0, 32'h0);
    sample(2);
    repeat (8) @(negedge clk);
    idle();
    #12 rst = 1'b1;

    next_cycle();
    rd(5'd1, 5'd0);
    expect_rd("post_reset_r1", 0, 32'h0, 32'h0);
    sample(2);

    // 1: basic write via port 0
    next_cycle();
    wr(0, 5'd1, 32'h0000_0233, 4'hF);
    rd(5'd1, 5'd0);
    expect_rd("t1_same_cycle", 0, 32'h0000_0233, 32'h0);
    sample(2);
    next_cycle();
    rd(5'd1, 5'd0);
    expect_rd("t1_rd0", 0, 32'h0000_0233, 32'h0000_0233);
    expect_rd("t1_rd1_r0", 1, 32'h0, 32'h0);
    sample(2);

    // 2: r0 writes discarded, even through bypass
    next_cycle();
    wr(0, 5'd0, 32'hDEAD_BEEF, 4'hF);
    wr(1, 5'd0, 32'hDEAD_BEEF, 4'hF);
    rd(5'd0, 5'd0);
    expect_rd("t2_r0_during", 0, 32'h0, 32'h0);
    sample(2);
    next_cycle();
    rd(5'd0, 5'd1);
    expect_rd("t2_r0_after", 0, 32'h0, 32'h0);
    expect_rd("t2_r1_kept", 1, 32'h0000_0233, 32'h0000_0233);
    sample(2);

    // 3: byte enables
    next_cycle();
    wr(0, 5'd2, 32'h1122_3344, 4'hF);
    next_cycle();
    wr(0, 5'd2, 32'hAABB_CCDD, 4'b0101);
    rd(5'd2, 5'd0);
    expect_rd("t3_same_cycle", 0, 32'h11BB_33DD, 32'h1122_3344);
    sample(2);
    next_cycle();
    wr(1, 5'd2, 32'hFFFF_FFFF, 4'h0);
    rd(5'd2, 5'd2);
    expect_rd("t3_merged", 0, 32'h11BB_33DD, 32'h11BB_33DD);
    expect_rd("t3_wbe0_rd1", 1, 32'h11BB_33DD, 32'h11BB_33DD);
    sample(2);
    next_cycle();
    rd(5'd2, 5'd0);
    expect_rd("t3_wbe_zero", 0, 32'h11BB_33DD, 32'h11BB_33DD);
    sample(2);

    // 4: same-address collision, resolved per byte
    next_cycle();
    wr(0, 5'd3, 32'h1111_1111, 4'hF);
    wr(1, 5'd3, 32'h2222_2222, 4'b0011);
    rd(5'd3, 5'd0);
    expect_rd("t4_same_cycle", 0, 32'h1111_2222, 32'h0);
    sample(2);
    next_cycle();
    rd(5'd3, 5'd3);
    expect_rd("t4_rd0", 0, 32'h1111_2222, 32'h1111_2222);
    expect_rd("t4_rd1", 1, 32'h1111_2222, 32'h1111_2222);
    sample(2);

    // 5: bypass vs stored value
    next_cycle();
    wr(0, 5'd4, 32'd5, 4'hF);
    next_cycle();
    wr(1, 5'd4, 32'd9, 4'hF);
    rd(5'd4, 5'd4);
    expect_rd("t5_same_rd0", 0, 32'd9, 32'd5);
    expect_rd("t5_same_rd1", 1, 32'd9, 32'd5);
    sample(2);
    next_cycle();
    rd(5'd4, 5'd4);
    expect_rd("t5_next_rd0", 0, 32'd9, 32'd9);
    expect_rd("t5_next_rd1", 1, 32'd9, 32'd9);
    sample(2);

    // 6: asynchronous reset with a write in flight
    next_cycle();
    wr(0, 5'd5, 32'h0000_ABCD, 4'hF);
    next_cycle();
    rd(5'd5, 5'd1);
    expect_rd("t6_pre_r5", 0, 32'h0000_ABCD, 32'h0000_ABCD);
    sample(2);
    next_cycle();
    wr(0, 5'd5, 32'h0000_1234, 4'hF);
    rd(5'd5, 5'd1);
    #2 rst = 1'b0;
    expect_rd("t6_rst_rd0", 0, 32'h0, 32'h0);
    expect_rd("t6_rst_rd1", 1, 32'h0, 32'h0);
    sample(1);
    repeat (2) @(negedge clk);
    idle();
    #2 rst = 1'b1;
    next_cycle();
    rd(5'd5, 5'd4);
    expect_rd("t6_after_r5", 0, 32'h0, 32'h0);
    expect_rd("t6_after_r4", 1, 32'h0, 32'h0);
    sample(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised multi-port general-purpose register file; next generation of the single-write, two-read `gpr`.
- Sits in the MIPS-lite datapath between decode (read addresses) and writeback (write ports). Designed for dual-issue or extra-port configurations.
- Adds the following beyond `gpr`:
  - configurable register count, data width and read-port count;
  - two write ports with defined collision priority;
  - per-byte write enables;
  - optional write-to-read bypass.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- NREG, 32, number of registers; power of two, >= 2.
- AW, 5, address width; must equal log2(NREG).
- NRD, 2, number of read ports; 1..4.
- BYPASS, 1, 1 = same-cycle forwarding of write data to reads; 0 = reads return stored value only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- SIG_RF_W0  input  1  write enable, port 0.
- waddr0  input  AW  write address, port 0.
- wdata0  input  DW  write data, port 0.
- wbe0  input  DW/8  byte enables, port 0; bit i covers wdata0[8i+7:8i].
- SIG_RF_W1  input  1  write enable, port 1.
- waddr1  input  AW  write address, port 1.
- wdata1  input  DW  write data, port 1.
- wbe1  input  DW/8  byte enables, port 1.
- raddr  input  NRD*AW  packed read addresses; port k uses slice [k*AW +: AW].
- rdata  output  NRD*DW  packed read data; port k uses slice [k*DW +: DW].

Behaviour:
- Reset:
  - rst low asynchronously clears every register to 0.
  - While rst is low, all writes are ignored and every rdata slice reads 0.
  - A write pending on the edge where rst deasserts is not performed if rst is still low at that edge.
- Register 0:
  - Hardwired zero; writes to address 0 on either port are discarded.
  - Reads of address 0 always return 0, including through bypass.
- Writes:
  - Take effect on the rising clk edge when SIG_RF_Wn=1 and rst=1.
  - Only bytes whose wbe bit is 1 are updated; the other bytes keep their old value.
  - If wbe is all zero, no change occurs.
- Write collision (waddr0 == waddr1, both enabled):
  - Resolved per byte; port 1 wins for every byte where wbe1 is set.
  - Port 0 supplies the bytes where only wbe0 is set.
  - Never an error.
- Reads are combinational (zero latency) from raddr to rdata; there is no read enable.
- Bypass when BYPASS=1:
  - For each read port and byte, if a write port is enabled, its address matches the read address (nonzero), and its byte enable is set, rdata returns that write's byte in the same cycle.
  - Forwarded bytes follow the same priority as writes: port 1 over port 0, then the stored byte.
- Bypass when BYPASS=0: rdata shows the stored value; a new value becomes visible after the clk edge.
- Addresses >= NREG are not possible, since NREG = 2^AW.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared include `gpr_defs.vh`:
  - GPR_ZERO_ADDR (0);
  - default DW/AW/NREG values;
  - a BYTES(DW) macro giving DW/8.
- Sub-module `gpr_rd_mux`: one instance per read port, generated NRD times. It performs the array lookup, the per-byte bypass compare/select with port-1 priority, and the r0 forcing.
- Top level holds the register array, reset logic and the byte-masked write merge.

Test Plan:
1. Reset then write, default parameters: hold rst=0 for 100 ns, release. Write 0x00000233 to r1 via port 0 with wbe=4'hF; next cycle set raddr0=1, raddr1=0 -> rdata0=0x00000233, rdata1=0.
2. r0 discard: write 0xDEADBEEF to r0 on both ports -> r0 reads 0, including during the write cycle with BYPASS=1.
3. Byte enables: r2=0x11223344; write 0xAABBCCDD with wbe=4'b0101 -> r2=0x11BB33DD.
4. Collision: same cycle, port 0 writes r3=0x11111111 with wbe=4'hF, port 1 writes 0x22222222 with wbe=4'b0011 -> r3=0x11112222. With BYPASS=1, a same-cycle read of r3 also shows 0x11112222.
5. Bypass mode: r4=5; write 9 to r4 with BYPASS=1 -> same-cycle rdata=9. With BYPASS=0 -> same cycle reads 5, next cycle reads 9.
6. Reset mid-operation: with r5=0x0000ABCD and a write in flight, pull rst low between clock edges -> all rdata become 0 immediately, and r5 still reads 0 after rst is released.
